hlpte_frame_streamer: RTL

- Parametrised successor to the HLPTE frame/parameter front end.
- Buffers NUM_FRAMES frames of FRAME_W x FRAME_H pixels.
- Accepts serial parameter sets (index, 4 quadrant mode bits, QP), then streams the selected frame as signed, QP-scaled values.
- New over the previous generation: generic geometry and widths, out_ready backpressure, busy status, and a sticky protocol-error flag.

---
 rtl/hlpte_frame_streamer.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/hlpte_frame_streamer.sv
// HLPTE frame streamer: buffers NUM_FRAMES raster frames, takes a 4-beat parameter
// burst and streams the selected frame as signed, QP-scaled values under backpressure.
module hlpte_frame_streamer #(
  parameter  int PIX_W      = 8,
  parameter  int FRAME_W    = 32,
  parameter  int FRAME_H    = 32,
  parameter  int NUM_FRAMES = 16,
  parameter  int QP_W       = 5,
  parameter  int OUT_W      = 32,
  localparam int IDX_W      = $clog2(NUM_FRAMES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_data,
  input  logic [PIX_W-1:0] data,
  input  logic             in_valid_param,
  input  logic [IDX_W-1:0] index,
  input  logic             mode,
  input  logic [QP_W-1:0]  QP,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_value,
  output logic             busy,
  output logic             err,
  output logic [1:0]       dbg_state
);
  // Handshake: a beat transfers on a rising edge where out_valid && out_ready; while
  // out_valid=1 and out_ready=0, out_value is held and no pipeline stage advances.

  localparam int XW     = $clog2(FRAME_W);
  localparam int YW     = $clog2(FRAME_H);
  localparam int PP_W   = XW + YW;
  localparam int ADDR_W = IDX_W + PP_W;
  localparam int DEPTH  = NUM_FRAMES * FRAME_W * FRAME_H;

  localparam logic [ADDR_W-1:0] WR_ONE = 1;
  localparam logic [PP_W:0]     RD_ONE = 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PARAM = 2'd1;
  localparam logic [1:0] S_FILL  = 2'd2;
  localparam logic [1:0] S_OUT   = 2'd3;

  logic [1:0]        r_state;
  logic [1:0]        r_beat;
  logic              r_fill_cnt;
  logic [IDX_W-1:0]  r_index;
  logic [QP_W-1:0]   r_qp;
  logic [3:0]        r_mode;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [PP_W:0]     r_rd_pos;
  logic              r_pix_valid;
  logic [1:0]        r_pix_quad;
  logic [PIX_W-1:0]  r_pix;
  logic              r_out_valid;
  logic [OUT_W-1:0]  r_out_value;
  logic              r_err;
  logic [PIX_W-1:0]  r_mem [DEPTH];

  logic                    w_streaming;
  logic                    w_adv;
  logic                    w_s1_load;
  logic                    w_rd_en;
  logic                    w_wr_en;
  logic                    w_last_hs;
  logic                    w_viol;
  logic [ADDR_W-1:0]       w_rd_addr;
  logic signed [PIX_W:0]   w_d;
  logic signed [OUT_W-1:0] w_d_ext;
  logic signed [OUT_W-1:0] w_qp1;
  logic signed [OUT_W-1:0] w_mul;
  logic signed [OUT_W-1:0] w_shl;
  logic signed [OUT_W-1:0] w_result;

  // Stage 1 is the registered RAM read, stage 2 the compute/output register.
  assign w_streaming = (r_state == S_FILL) || (r_state == S_OUT);
  assign w_adv       = !r_out_valid || out_ready;
  assign w_s1_load   = w_streaming && (!r_pix_valid || w_adv);
  assign w_rd_en     = w_s1_load && !r_rd_pos[PP_W];
  assign w_rd_addr   = {r_index, r_rd_pos[PP_W-1:0]};
  assign w_wr_en     = (r_state == S_IDLE) && in_valid_data && !in_valid_param;
  assign w_last_hs   = (r_state == S_OUT) && r_out_valid && out_ready && !r_pix_valid;
  assign w_viol      = (in_valid_data && ((r_state != S_IDLE) || in_valid_param))
                    || (in_valid_param && w_streaming)
                    || ((r_state == S_PARAM) && !in_valid_param);

  // pixel - 2^(PIX_W-1) is the pixel with its MSB inverted, sign-extended one bit.
  assign w_d      = {~r_pix[PIX_W-1], ~r_pix[PIX_W-1], r_pix[PIX_W-2:0]};
  assign w_d_ext  = {{(OUT_W-PIX_W-1){w_d[PIX_W]}}, w_d};
  assign w_qp1    = {{(OUT_W-QP_W-1){1'b0}}, ({1'b0, r_qp} + {{QP_W{1'b0}}, 1'b1})};
  assign w_mul    = w_d_ext * w_qp1;
  assign w_shl    = w_d_ext <<< r_qp[2:0];
  assign w_result = r_mode[r_pix_quad] ? w_mul : w_shl;

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= data;
    if (w_rd_en) r_pix <= r_mem[w_rd_addr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_beat      <= '0;
      r_fill_cnt  <= 1'b0;
      r_index     <= '0;
      r_qp        <= '0;
      r_mode      <= '0;
      r_wr_ptr    <= '0;
      r_rd_pos    <= '0;
      r_pix_valid <= 1'b0;
      r_pix_quad  <= '0;
      r_out_valid <= 1'b0;
      r_out_value <= '0;
      r_err       <= 1'b0;
    end else begin
      if (w_viol) r_err <= 1'b1;
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + WR_ONE;

      case (r_state)
        S_IDLE: begin
          if (in_valid_param) begin
            r_state   <= S_PARAM;
            r_beat    <= 2'd1;
            r_index   <= index;
            r_qp      <= QP;
            r_mode[0] <= mode;
            r_rd_pos  <= '0;
          end
        end
        S_PARAM: begin
          if (in_valid_param) begin
            r_mode[r_beat] <= mode;
            r_beat         <= r_beat + 2'd1;
            if (r_beat == 2'd3) begin
              r_state    <= S_FILL;
              r_fill_cnt <= 1'b0;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_FILL: begin
          r_fill_cnt <= 1'b1;
          if (r_fill_cnt) r_state <= S_OUT;
        end
        default: begin
          if (w_last_hs) r_state <= S_IDLE;
        end
      endcase

      // Quadrant: bottom half from the row MSB, right half from the column MSB.
      if (w_rd_en) begin
        r_rd_pos   <= r_rd_pos + RD_ONE;
        r_pix_quad <= {r_rd_pos[PP_W-1], r_rd_pos[XW-1]};
      end
      if (w_s1_load) r_pix_valid <= w_rd_en;
      if (w_streaming && w_adv) begin
        r_out_valid <= r_pix_valid;
        r_out_value <= r_pix_valid ? w_result : '0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_value = r_out_value;
  assign busy      = (r_state != S_IDLE);
  assign err       = r_err;
  assign dbg_state = r_state;

endmodule
